task_dispatcher: RTL

- Downstream consumer of the per-task `out_sorter` words.
- Scans the `{task_id, priority}` words from NUM_TASKS task blocks, one per cycle, and selects the ready task with the highest priority.
- Drives an Execute op on the shared 16-bit task op bus, waits for the task's `exe_flag`, runs a fixed time slice, then issues Finish execution.
- Sits between the task array and the op bus as the scheduler core.

---
 rtl/task_dispatcher.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/task_dispatcher.sv
// ============================================================================
// Module   : task_dispatcher
// Brief    : Scans NUM_TASKS {id, prio} words, dispatches the highest-priority
//            ready task on the op bus, waits for its exe_flag, runs a fixed
//            time slice and issues Finish. Optional ROUND_ROBIN_TIE_EN rotates
//            the scan start point for fairness among equal priorities.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module task_dispatcher #(
    parameter int NUM_TASKS    = 8,
    parameter int SLICE_CYCLES = 1000,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [NUM_TASKS*16-1:0]   task_words,
    input  logic [NUM_TASKS-1:0]      exe_flags,
    output logic [15:0]               out_op,
    output logic                      op_valid,
    output logic                      busy,
    output logic [7:0]                sel_id,
    output logic                      no_ready,
    output logic                      ack_err
);

    localparam int IDX_W   = (NUM_TASKS    > 1) ? $clog2(NUM_TASKS)    : 1;
    localparam int ACK_W   = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
    localparam int SLICE_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;

    localparam logic [IDX_W-1:0]   c_LAST_IDX   = IDX_W'(NUM_TASKS - 1);
    localparam logic [ACK_W-1:0]   c_ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [SLICE_W-1:0] c_SLICE_LAST = SLICE_W'(SLICE_CYCLES - 1);
    localparam logic [3:0]         c_OP_EXE     = 4'h7;
    localparam logic [3:0]         c_OP_FIN     = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SCAN      = 3'd1,
        S_ISSUE_EXE = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_RUN       = 3'd4,
        S_ISSUE_FIN = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_scan_cnt;
    logic                 r_best_valid;
    logic [7:0]           r_best_prio;
    logic [7:0]           r_best_id;
    logic [IDX_W-1:0]     r_best_idx;
    logic [7:0]           r_sel_id;
    logic [IDX_W-1:0]     r_sel_idx;
    logic [ACK_W-1:0]     r_ack_cnt;
    logic [SLICE_W-1:0]   r_slice_cnt;
    logic                 r_no_ready;

    logic [15:0]          w_words [NUM_TASKS];
    logic [15:0]          w_word;
    logic                 w_take;
    logic                 w_found;
    logic                 w_scan_last;
    logic                 w_flag;
    logic [IDX_W-1:0]     w_idx_inc;
    logic [IDX_W-1:0]     w_scan_start;
    logic [7:0]           w_sel_id_nxt;
    logic [IDX_W-1:0]     w_sel_idx_nxt;

    for (genvar g = 0; g < NUM_TASKS; g++) begin : g_unpack
        assign w_words[g] = task_words[16*g +: 16];
    end

    assign w_word      = w_words[r_idx];
    // Strict compare: the earliest visited index keeps a tie
    assign w_take      = (|w_word) && (!r_best_valid || (w_word[7:0] > r_best_prio));
    assign w_found     = r_best_valid || w_take;
    assign w_scan_last = (r_scan_cnt == c_LAST_IDX);
    assign w_flag      = exe_flags[r_sel_idx];
    assign w_idx_inc   = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

    assign w_sel_id_nxt  = w_take ? w_word[15:8] : r_best_id;
    assign w_sel_idx_nxt = w_take ? r_idx        : r_best_idx;

`ifdef ROUND_ROBIN_TIE_EN
    logic [IDX_W-1:0]     r_last_idx;

    assign w_scan_start = (r_last_idx == c_LAST_IDX) ? '0 : r_last_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_idx <= c_LAST_IDX;
        end else if (r_state == S_SCAN && w_scan_last && w_found) begin
            r_last_idx <= w_sel_idx_nxt;
        end
    end
`else
    assign w_scan_start = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_op      = 16'h0000;
        op_valid    = 1'b0;
        ack_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_scan_last) begin
                    w_state_nxt = w_found ? S_ISSUE_EXE : S_IDLE;
                end
            end
            S_ISSUE_EXE: begin
                out_op      = {4'h0, r_sel_id[3:0], c_OP_EXE, 4'h0};
                op_valid    = 1'b1;
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_flag) begin
                    w_state_nxt = S_RUN;
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    ack_err     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // A task that drops its flag has left on its own; no Finish
                if (!w_flag) begin
                    w_state_nxt = S_IDLE;
                end else if (r_slice_cnt == c_SLICE_LAST) begin
                    w_state_nxt = S_ISSUE_FIN;
                end
            end
            S_ISSUE_FIN: begin
                out_op      = {4'h0, r_sel_id[3:0], c_OP_FIN, 4'h0};
                op_valid    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx        <= '0;
            r_scan_cnt   <= '0;
            r_best_valid <= 1'b0;
            r_best_prio  <= '0;
            r_best_id    <= '0;
            r_best_idx   <= '0;
            r_sel_id     <= '0;
            r_sel_idx    <= '0;
            r_ack_cnt    <= '0;
            r_slice_cnt  <= '0;
            r_no_ready   <= 1'b0;
        end else begin
            r_no_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx        <= w_scan_start;
                        r_scan_cnt   <= '0;
                        r_best_valid <= 1'b0;
                        r_best_prio  <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_take) begin
                        r_best_valid <= 1'b1;
                        r_best_prio  <= w_word[7:0];
                        r_best_id    <= w_word[15:8];
                        r_best_idx   <= r_idx;
                    end
                    r_idx <= w_idx_inc;
                    if (w_scan_last) begin
                        if (w_found) begin
                            r_sel_id  <= w_sel_id_nxt;
                            r_sel_idx <= w_sel_idx_nxt;
                        end else begin
                            r_no_ready <= 1'b1;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                S_ISSUE_EXE: begin
                    r_ack_cnt <= '0;
                end
                S_WAIT_ACK: begin
                    if (w_flag) begin
                        r_slice_cnt <= '0;
                    end else if (r_ack_cnt != c_ACK_LAST) begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_slice_cnt != c_SLICE_LAST) begin
                        r_slice_cnt <= r_slice_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign sel_id   = r_sel_id;
    assign no_ready = r_no_ready;

endmodule

`default_nettype wire
